program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter RAM_BYTES, default 16, number of RAM bytes loaded per session (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port start  input  1  single-cycle request to begin a load session.
REQ-005 SHALL have port in_data  input  8  host byte (program byte or checksum).
REQ-006 SHALL have port in_valid  input  1  host byte valid.
REQ-007 SHALL have port in_ready  output  1  loader accepts in_data this cycle.
REQ-008 SHALL have port cpu_hold  output  1  holds CPU in reset while loading (active-high).
REQ-009 SHALL have port bus_en  output  1  loader drives the CPU bus.
REQ-010 SHALL have port bus_data  output  8  value driven on the bus when bus_en=1, else 0.
REQ-011 SHALL have port n_load_addr  output  1  MAR address load strobe (active-low).
REQ-012 SHALL have port n_load_data  output  1  MAR data load strobe (active-low).
REQ-013 SHALL have port n_we  output  1  RAM write strobe (active-low).
REQ-014 SHALL have port done  output  1  session finished, checksum matched (sticky).
REQ-015 SHALL have port err  output  1  session finished, checksum mismatch (sticky).

Function
REQ-016 SHALL implement states IDLE, WAIT_BYTE, ADDR, DATA, WRITE, WAIT_SUM, FINISH.
REQ-017 IDLE: start=1 -> WAIT_BYTE next cycle; clears addr counter, checksum, done, err; start ignored outside IDLE and FINISH.
REQ-018 FINISH: holds done/err; start=1 -> WAIT_BYTE with the same clears as IDLE.
REQ-019 in_ready SHALL be 1 only in WAIT_BYTE and WAIT_SUM; a byte transfers when in_valid=1 and in_ready=1 on the same edge.
REQ-020 WAIT_BYTE transfer: latch byte, checksum += byte (mod 256), -> ADDR.
REQ-021 ADDR (1 cycle): bus_en=1, bus_data={4'b0, addr}, n_load_addr=0 -> DATA.
REQ-022 DATA (1 cycle): bus_en=1, bus_data=latched byte, n_load_data=0 -> WRITE.
REQ-023 WRITE (1 cycle): n_we=0, bus_en=0; if addr=RAM_BYTES-1 -> WAIT_SUM, else addr+1 -> WAIT_BYTE.
REQ-024 Per-byte cost SHALL be exactly 3 cycles after the accepting edge; at most one strobe low per cycle.
REQ-025 WAIT_SUM transfer: err = (in_data != checksum), done = !err, -> FINISH next cycle.
REQ-026 cpu_hold SHALL be 1 in every state except IDLE and FINISH.
REQ-027 in_valid=0 in WAIT_BYTE/WAIT_SUM SHALL stall indefinitely with no strobe activity.
REQ-028 Address counter SHALL be 4 bits, never wrap within a session; reset to 0 at session start.
REQ-029 All outputs SHALL be registered (or decoded from registered state only); no combinational path from in_valid/in_data to strobes.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, in_ready=0, cpu_hold=0, bus_en=0, bus_data=0, n_load_addr=n_load_data=n_we=1, done=err=0, addr=0, checksum=0.
REQ-031 rst asserted mid-session SHALL abort without any further strobe; RAM contents are then undefined; no resume.

Structure
REQ-032 State encoding and strobe-idle constants SHALL live in shared package cpu_pkg.
REQ-033 Single module; no sub-modules required.

Verification
REQ-034 Reset, start, 16 bytes 0x00..0x0F back-to-back, checksum 0x78 -> 16 addr/data/write triplets, addresses 0..15, done=1, err=0, cpu_hold falls on FINISH.
REQ-035 Same load, checksum 0x77 -> err=1, done=0, all 16 writes still issued.
REQ-036 in_valid deasserted 5 cycles before byte 3 -> no strobes during stall, in_ready stays 1, sequence resumes intact.
REQ-037 rst pulse during DATA of byte 7 -> all strobes high and cpu_hold=0 asynchronously; subsequent start reloads from address 0.
REQ-038 start pulses while in WRITE and WAIT_BYTE -> ignored; second start in FINISH -> new session, done/err cleared.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader: state encoding, strobe levels
// and the running checksum helper.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BYTE = 3'd1,
    ST_ADDR      = 3'd2,
    ST_DATA      = 3'd3,
    ST_WRITE     = 3'd4,
    ST_WAIT_SUM  = 3'd5,
    ST_FINISH    = 3'd6
  } state_t;

  localparam logic STROBE_IDLE   = 1'b1;
  localparam logic STROBE_ACTIVE = 1'b0;

  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/program_loader.sv
// Host-to-RAM program loader: streams RAM_BYTES bytes onto the CPU bus as
// address/data/write strobe triplets, then verifies a modulo-256 checksum.
module program_loader
  import cpu_pkg::*;
#(
  parameter int RAM_BYTES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       cpu_hold,
  output logic       bus_en,
  output logic [7:0] bus_data,
  output logic       n_load_addr,
  output logic       n_load_data,
  output logic       n_we,
  output logic       done,
  output logic       err
);

  localparam logic [3:0] LAST_ADDR = 4'(RAM_BYTES - 1);

  state_t     state_r, state_s;
  logic [3:0] addr_r, addr_s;
  logic [7:0] byte_r, byte_s;
  logic [7:0] sum_r, sum_s;
  logic       done_r, done_s;
  logic       err_r, err_s;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      addr_r  <= 4'd0;
      byte_r  <= 8'd0;
      sum_r   <= 8'd0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      addr_r  <= addr_s;
      byte_r  <= byte_s;
      sum_r   <= sum_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    byte_s  = byte_r;
    sum_s   = sum_r;
    done_s  = done_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE, ST_FINISH: begin
        if (start) begin
          state_s = ST_WAIT_BYTE;
          addr_s  = 4'd0;
          sum_s   = 8'd0;
          done_s  = 1'b0;
          err_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_WAIT_BYTE: begin
        if (in_valid) begin
          byte_s  = in_data;
          sum_s   = csum_add(sum_r, in_data);
          state_s = ST_ADDR;
        end else begin
          state_s = ST_WAIT_BYTE;
        end
      end
      ST_ADDR:  state_s = ST_DATA;
      ST_DATA:  state_s = ST_WRITE;
      ST_WRITE: begin
        // The counter stops at the last address so it never wraps in a session
        if (addr_r == LAST_ADDR) begin
          state_s = ST_WAIT_SUM;
        end else begin
          addr_s  = addr_r + 4'd1;
          state_s = ST_WAIT_BYTE;
        end
      end
      ST_WAIT_SUM: begin
        if (in_valid) begin
          err_s   = (in_data != sum_r);
          done_s  = (in_data == sum_r);
          state_s = ST_FINISH;
        end else begin
          state_s = ST_WAIT_SUM;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state only, so reset forces them at once
  always_comb begin
    in_ready    = 1'b0;
    cpu_hold    = 1'b1;
    bus_en      = 1'b0;
    bus_data    = 8'd0;
    n_load_addr = STROBE_IDLE;
    n_load_data = STROBE_IDLE;
    n_we        = STROBE_IDLE;
    case (state_r)
      ST_IDLE, ST_FINISH: cpu_hold = 1'b0;
      ST_WAIT_BYTE, ST_WAIT_SUM: in_ready = 1'b1;
      ST_ADDR: begin
        bus_en      = 1'b1;
        bus_data    = {4'b0000, addr_r};
        n_load_addr = STROBE_ACTIVE;
      end
      ST_DATA: begin
        bus_en      = 1'b1;
        bus_data    = byte_r;
        n_load_data = STROBE_ACTIVE;
      end
      ST_WRITE: n_we = STROBE_ACTIVE;
      default: cpu_hold = 1'b0;
    endcase
  end

  assign done = done_r;
  assign err  = err_r;

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       cpu_hold;
  logic       bus_en;
  logic [7:0] bus_data;
  logic       n_load_addr;
  logic       n_load_data;
  logic       n_we;
  logic       done;
  logic       err;

  int tests = 0;
  int fails = 0;

  // bus monitor state
  int         wr_cnt = 0;
  int         strobe_cnt = 0;
  int         multi_low = 0;
  int         bad_bus = 0;
  logic [7:0] cur_addr = 8'd0;
  logic [7:0] cur_data = 8'd0;
  logic [7:0] addr_seq [0:255];
  logic [7:0] data_seq [0:255];

  program_loader #(.RAM_BYTES(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .cpu_hold(cpu_hold),
    .bus_en(bus_en), .bus_data(bus_data), .n_load_addr(n_load_addr),
    .n_load_data(n_load_data), .n_we(n_we), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    int nlow;
    nlow = 32'(!n_load_addr) + 32'(!n_load_data) + 32'(!n_we);
    strobe_cnt += nlow;
    if (nlow > 1) multi_low++;
    if (!n_load_addr) begin
      cur_addr = bus_data;
      if (!bus_en) bad_bus++;
    end
    if (!n_load_data) begin
      cur_data = bus_data;
      if (!bus_en) bad_bus++;
    end
    if (!n_we) begin
      if (wr_cnt < 256) begin
        addr_seq[wr_cnt] = cur_addr;
        data_seq[wr_cnt] = cur_data;
      end
      wr_cnt++;
      if (bus_en) bad_bus++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    chk(tag, 32'(k < 50), 32'd1);
  endtask

  // present a byte, wait for acceptance, then drop valid; returns in ADDR
  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    wait_ready("ready_timeout");
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_load(input string tag, input int base, input logic [7:0] dbase);
    chk({tag, "_writes"}, 32'(wr_cnt - base), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk({tag, "_addr"}, {24'd0, addr_seq[base + i]}, i);
      chk({tag, "_data"}, {24'd0, data_seq[base + i]}, {24'd0, dbase + 8'(i)});
    end
  endtask

  initial begin
    int base;
    int snap_s;
    int snap_w;
    rst = 1'b1;
    start = 1'b0;
    in_data = 8'd0;
    in_valid = 1'b0;
    step();
    step();
    // reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd0);
    chk("rst_bus_en", {31'd0, bus_en}, 32'd0);
    chk("rst_bus_data", {24'd0, bus_data}, 32'd0);
    chk("rst_strobes", {29'd0, n_load_addr, n_load_data, n_we}, 32'd7);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    rst = 1'b0;
    step();

    // session 1: 0x00..0x0F back to back, good checksum 0x78
    base = wr_cnt;
    pulse_start();
    chk("s1_in_ready", {31'd0, in_ready}, 32'd1);
    chk("s1_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'h78);
    chk("s1_done_err", {30'd0, done, err}, 32'b10);
    chk("s1_cpu_hold_fin", {31'd0, cpu_hold}, 32'd0);
    chk("s1_in_ready_fin", {31'd0, in_ready}, 32'd0);
    check_load("s1", base, 8'h00);

    // session 2 started from FINISH: flags clear, bad checksum 0x77
    base = wr_cnt;
    pulse_start();
    chk("s2_flags_clear", {30'd0, done, err}, 32'd0);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'h77);
    chk("s2_done_err", {30'd0, done, err}, 32'b01);
    check_load("s2", base, 8'h00);

    // session 3: start pulses in WRITE and WAIT_BYTE, stall before byte 3
    base = wr_cnt;
    pulse_start();
    send_byte(8'h00);
    step();
    step();
    chk("s3_in_write", {31'd0, n_we}, 32'd0);
    pulse_start();
    chk("s3_wait_byte", {31'd0, in_ready}, 32'd1);
    pulse_start();
    chk("s3_wait_hold", {30'd0, in_ready, cpu_hold}, 32'b11);
    for (int i = 1; i < 16; i++) begin
      if (i == 3) begin
        wait_ready("s3_stall_ready");
        snap_s = strobe_cnt;
        for (int c = 0; c < 5; c++) begin
          step();
          chk("s3_stall_in_ready", {31'd0, in_ready}, 32'd1);
        end
        chk("s3_stall_strobes", strobe_cnt - snap_s, 32'd0);
      end
      send_byte(8'(i));
    end
    send_byte(8'h78);
    chk("s3_done_err", {30'd0, done, err}, 32'b10);
    check_load("s3", base, 8'h00);

    // session 4: reset during DATA of byte 7, then reload from address 0
    base = wr_cnt;
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    step();
    chk("s4_in_data", {31'd0, n_load_data}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("s4_async_strobes", {29'd0, n_load_addr, n_load_data, n_we}, 32'd7);
    chk("s4_async_hold", {30'd0, cpu_hold, bus_en}, 32'd0);
    chk("s4_async_bus", {24'd0, bus_data}, 32'd0);
    snap_w = wr_cnt;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    chk("s4_no_write", wr_cnt - snap_w, 32'd0);
    chk("s4_writes_before", snap_w - base, 32'd7);
    chk("s4_idle_flags", {29'd0, done, err, in_ready}, 32'd0);
    base = wr_cnt;
    pulse_start();
    for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i));
    send_byte(8'h78);
    chk("s4_done_err", {30'd0, done, err}, 32'b10);
    check_load("s4", base, 8'hA0);

    chk("one_strobe_low", multi_low, 32'd0);
    chk("bus_en_strobes", bad_bus, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
